link_recovery_ctrl: RTL and testbench

- Supervisory controller for the TDS receive chain: GTP receiver, strip/pad deserializers and strip/pad checkers, all checked on clk160.
- Sequences the link bring-up: GTP soft reset, settle wait, checker reset, lock wait.
- Monitors the lock and error status of the selected checkers and retries bring-up on loss of lock or excess errors.
- Declares FAIL after a bounded number of retries; reports state, retry count and uptime for VIO/ILA readout.

---
 rtl/link_recovery_ctrl.sv | 140 ++++++++++++++
 tb/tb_link_recovery_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/link_recovery_ctrl.sv
// Supervisory bring-up/retry controller for the TDS receive chain (GTP + strip/pad checkers).
// Sequences GTP reset, settle, checker reset and lock wait, then monitors and retries on faults.
module link_recovery_ctrl #(
    parameter int RST_CYCLES    = 16,
    parameter int SETTLE_CYCLES = 4096,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int ERR_LIMIT     = 16,
    parameter int MAX_RETRY     = 7
) (
    input  logic        clk160,
    input  logic        reset,
    input  logic        enable,
    input  logic        relink,
    input  logic [1:0]  lane_mask,
    input  logic        strip_linked,
    input  logic [4:0]  strip_err_cnt,
    input  logic        pad_linked,
    input  logic [4:0]  pad_err_cnt,
    output logic        gtp_reset,
    output logic        checker_reset,
    output logic        link_up,
    output logic        fail,
    output logic [2:0]  state,
    output logic [7:0]  retry_cnt,
    output logic [31:0] uptime
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RST_GTP   = 3'd1,
        S_SETTLE    = 3'd2,
        S_RST_CHK   = 3'd3,
        S_WAIT_LOCK = 3'd4,
        S_LINKED    = 3'd5,
        S_FAIL      = 3'd6
    } state_t;

    localparam logic [31:0] RST_LAST    = 32'(RST_CYCLES - 1);
    localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
    localparam logic [31:0] LOCK_LAST   = 32'(LOCK_TIMEOUT - 1);
    localparam logic [4:0]  ERR_LIM     = 5'(ERR_LIMIT);
    localparam logic [7:0]  RETRY_MAX   = 8'(MAX_RETRY);

    state_t      state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic [7:0]  retry_q, retry_d;
    logic [31:0] uptime_q, uptime_d;

    logic [1:0] req;
    logic       strip_ok, pad_ok, ok;
    logic       do_retry, restart, timed;

    // An all-zero mask would require nothing, so it is read as "both lanes required".
    assign req      = (lane_mask == 2'b00) ? 2'b11 : lane_mask;
    assign strip_ok = !req[0] || (strip_linked && (strip_err_cnt < ERR_LIM));
    assign pad_ok   = !req[1] || (pad_linked && (pad_err_cnt < ERR_LIM));
    assign ok       = strip_ok && pad_ok;

    assign timed = (state_q == S_RST_GTP) || (state_q == S_SETTLE) ||
                   (state_q == S_RST_CHK) || (state_q == S_WAIT_LOCK);

    always_comb begin
        state_d  = state_q;
        retry_d  = retry_q;
        do_retry = 1'b0;
        restart  = 1'b0;
        if (!enable) begin
            state_d = S_IDLE;
            retry_d = '0;
        end else if (relink && (state_q != S_IDLE)) begin
            state_d = S_RST_GTP;
            retry_d = '0;
            restart = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_RST_GTP;
                    retry_d = '0;
                end
                S_RST_GTP:   if (timer_q == RST_LAST) state_d = S_SETTLE;
                S_SETTLE:    if (timer_q == SETTLE_LAST) state_d = S_RST_CHK;
                S_RST_CHK:   if (timer_q == RST_LAST) state_d = S_WAIT_LOCK;
                S_WAIT_LOCK: begin
                    if (ok) state_d = S_LINKED;
                    else if (timer_q == LOCK_LAST) do_retry = 1'b1;
                end
                S_LINKED:    if (!ok) do_retry = 1'b1;
                S_FAIL:      state_d = S_FAIL;
                default:     state_d = S_IDLE;
            endcase
            if (do_retry) begin
                if (retry_q == RETRY_MAX) begin
                    state_d = S_FAIL;
                end else begin
                    retry_d = retry_q + 8'd1;
                    state_d = S_RST_GTP;
                    restart = (state_q == S_RST_GTP);
                end
            end
        end
    end

    always_comb begin
        timer_d = timer_q;
        if ((state_d != state_q) || restart) timer_d = '0;
        else if (timed) timer_d = timer_q + 32'd1;
    end

    // uptime restarts at each LINKED entry and otherwise holds outside LINKED.
    always_comb begin
        uptime_d = uptime_q;
        if (state_d == S_LINKED) begin
            if (state_q != S_LINKED) uptime_d = '0;
            else if (uptime_q != 32'hFFFF_FFFF) uptime_d = uptime_q + 32'd1;
        end
    end

    always_ff @(posedge clk160) begin
        if (reset) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            retry_q  <= '0;
            uptime_q <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            retry_q  <= retry_d;
            uptime_q <= uptime_d;
        end
    end

    assign gtp_reset     = (state_q == S_RST_GTP);
    assign checker_reset = (state_q == S_RST_CHK);
    assign link_up       = (state_q == S_LINKED);
    assign fail          = (state_q == S_FAIL);
    assign state         = state_q;
    assign retry_cnt     = retry_q;
    assign uptime        = uptime_q;

endmodule

// File: tb/tb_link_recovery_ctrl.sv
// Directed bench for link_recovery_ctrl: bring-up timing, loss of lock, error limit,
// timeout to FAIL, aborts, reset and simultaneous control events.
module tb_link_recovery_ctrl;

    logic        clk160 = 1'b0;
    logic        reset, enable, relink;
    logic [1:0]  lane_mask;
    logic        strip_linked, pad_linked;
    logic [4:0]  strip_err_cnt, pad_err_cnt;
    logic        gtp_reset, checker_reset, link_up, fail;
    logic [2:0]  state;
    logic [7:0]  retry_cnt;
    logic [31:0] uptime;

    int total = 0;
    int bad   = 0;
    int n;

    link_recovery_ctrl #(
        .RST_CYCLES(4), .SETTLE_CYCLES(16), .LOCK_TIMEOUT(100), .ERR_LIMIT(8), .MAX_RETRY(3)
    ) dut (
        .clk160(clk160), .reset(reset), .enable(enable), .relink(relink),
        .lane_mask(lane_mask), .strip_linked(strip_linked), .strip_err_cnt(strip_err_cnt),
        .pad_linked(pad_linked), .pad_err_cnt(pad_err_cnt), .gtp_reset(gtp_reset),
        .checker_reset(checker_reset), .link_up(link_up), .fail(fail), .state(state),
        .retry_cnt(retry_cnt), .uptime(uptime)
    );

    always #5 clk160 = ~clk160;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk160);
        #1;
    endtask

    task automatic wait_for(input logic [2:0] s, input int lim, input string tag);
        int k = 0;
        while (state !== s && k < lim) begin
            tick();
            k++;
        end
        chk(tag, 32'(state), 32'(s));
    endtask

    task automatic count_in(input logic [2:0] s, output int cnt);
        cnt = 0;
        while (state === s && cnt < 1000) begin
            cnt++;
            tick();
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; relink = 1'b0; lane_mask = 2'b11;
        strip_linked = 1'b0; pad_linked = 1'b0; strip_err_cnt = 5'd0; pad_err_cnt = 5'd0;
        tick(); tick();
        chk("rst_state", 32'(state), 0);
        chk("rst_outs", {gtp_reset, checker_reset, link_up, fail}, 0);
        chk("rst_retry", 32'(retry_cnt), 0);
        chk("rst_uptime", uptime, 0);
        reset = 1'b0;
        tick();
        chk("idle_hold", 32'(state), 0);

        // nominal bring-up
        enable = 1'b1;
        tick();
        chk("go_rst_gtp", 32'(state), 1);
        chk("gtp_on", 32'(gtp_reset), 1);
        count_in(3'd1, n);  chk("gtp_len", 32'(n), 4);
        chk("settle_in", 32'(state), 2);
        chk("settle_rst", {gtp_reset, checker_reset}, 0);
        count_in(3'd2, n);  chk("settle_len", 32'(n), 16);
        chk("chk_on", 32'(checker_reset), 1);
        count_in(3'd3, n);  chk("chk_len", 32'(n), 4);
        chk("wait_in", 32'(state), 4);
        repeat (10) tick();
        chk("wait_10", 32'(state), 4);
        strip_linked = 1'b1; pad_linked = 1'b1;
        tick();
        chk("linked", 32'(state), 5);
        chk("link_up", 32'(link_up), 1);
        chk("retry0", 32'(retry_cnt), 0);
        chk("uptime0", uptime, 0);
        repeat (50) tick();
        chk("uptime50", uptime, 50);

        // loss of lock for one cycle
        pad_linked = 1'b0;
        tick();
        pad_linked = 1'b1;
        chk("lol_state", 32'(state), 1);
        chk("lol_retry", 32'(retry_cnt), 1);
        chk("lol_linkup", 32'(link_up), 0);
        chk("lol_uptime", uptime, 50);

        // error threshold
        wait_for(3'd5, 200, "relock1");
        strip_err_cnt = 5'd7;
        tick();
        chk("err7_stay", 32'(state), 5);
        strip_err_cnt = 5'd8;
        tick();
        chk("err8_retry", 32'(state), 1);
        chk("err8_cnt", 32'(retry_cnt), 2);
        lane_mask = 2'b10;
        wait_for(3'd5, 200, "relock_mask10");
        repeat (5) tick();
        chk("mask10_stay", 32'(state), 5);
        chk("mask10_cnt", 32'(retry_cnt), 2);
        lane_mask = 2'b00;
        tick();
        chk("mask00_retry", 32'(state), 1);
        chk("mask00_cnt", 32'(retry_cnt), 3);

        // timeout to FAIL
        strip_linked = 1'b0; pad_linked = 1'b0; strip_err_cnt = 5'd0; lane_mask = 2'b11;
        relink = 1'b1;
        tick();
        relink = 1'b0;
        chk("relink_state", 32'(state), 1);
        chk("relink_cnt", 32'(retry_cnt), 0);
        wait_for(3'd4, 200, "reach_wait");
        count_in(3'd4, n);  chk("timeout_len", 32'(n), 100);
        chk("to_state", 32'(state), 1);
        chk("to_cnt", 32'(retry_cnt), 1);
        wait_for(3'd6, 1000, "reach_fail");
        chk("fail_cnt", 32'(retry_cnt), 3);
        chk("fail_flag", 32'(fail), 1);
        chk("fail_rst", {gtp_reset, checker_reset}, 0);
        relink = 1'b1;
        tick();
        relink = 1'b0;
        chk("unfail_state", 32'(state), 1);
        chk("unfail_cnt", 32'(retry_cnt), 0);
        chk("unfail_flag", 32'(fail), 0);

        // abort during checker reset
        wait_for(3'd3, 100, "reach_rstchk");
        chk("abort_pre", 32'(checker_reset), 1);
        enable = 1'b0;
        tick();
        chk("abort_state", 32'(state), 0);
        chk("abort_chk", 32'(checker_reset), 0);

        // synchronous reset while linked
        strip_linked = 1'b1; pad_linked = 1'b1; enable = 1'b1;
        wait_for(3'd5, 200, "relock2");
        chk("relock2_up", 32'(link_up), 1);
        reset = 1'b1;
        tick();
        chk("srst_state", 32'(state), 0);
        chk("srst_outs", {gtp_reset, checker_reset, link_up, fail}, 0);
        chk("srst_cnt", 32'(retry_cnt), 0);
        chk("srst_uptime", uptime, 0);
        reset = 1'b0;
        tick();
        chk("post_srst", 32'(state), 1);

        // relink and enable=0 together
        relink = 1'b1; enable = 1'b0;
        tick();
        relink = 1'b0;
        chk("simul_state", 32'(state), 0);
        chk("simul_gtp", 32'(gtp_reset), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
